// File: rtl/int_csr_ctrl_pkg.sv
// Shared definitions for the trap/interrupt sequencer: CSR addresses, cause codes,
// mstatus/mie bit positions and the FSM state encoding.
package int_csr_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] CAUSE_ECALL_C  = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK_C = 32'd3;
    localparam logic [31:0] CAUSE_TIMER_C  = 32'h8000_0007;
    localparam logic [31:0] CAUSE_EXT_C    = 32'h8000_000B;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int MIE_MTIE = 7;
    localparam int MIE_MEIE = 11;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SAVE_EPC    = 3'd1,
        ST_SAVE_CAUSE  = 3'd2,
        ST_SAVE_STATUS = 3'd3,
        ST_JUMP        = 3'd4,
        ST_MRET_STATUS = 3'd5,
        ST_MRET_JUMP   = 3'd6
    } state_e;

endpackage

// File: rtl/int_csr_ctrl_if.sv
// Interrupt-side CSR port between the trap sequencer (master) and the CSR file (slave),
// including the CSR state the sequencer observes.
interface int_csr_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              csr_we;
    logic [ADDR_W-1:0] csr_raddr;
    logic [ADDR_W-1:0] csr_waddr;
    logic [DATA_W-1:0] csr_wdata;
    logic [DATA_W-1:0] csr_rdata;
    logic [DATA_W-1:0] csr_mtvec;
    logic [DATA_W-1:0] csr_mepc;
    logic [DATA_W-1:0] csr_mstatus;
    logic              global_int_en;

    modport master (
        output csr_we, csr_raddr, csr_waddr, csr_wdata,
        input  csr_rdata, csr_mtvec, csr_mepc, csr_mstatus, global_int_en
    );

    modport slave (
        input  csr_we, csr_raddr, csr_waddr, csr_wdata,
        output csr_rdata, csr_mtvec, csr_mepc, csr_mstatus, global_int_en
    );
endinterface

// File: rtl/int_csr_ctrl.sv
// Trap/interrupt sequencer: stalls the pipeline, saves mepc/mcause/mstatus one CSR per cycle
// and redirects the PC. Optional vectored mtvec mode is enabled with `define INT_VECTORED_EN.
module int_csr_ctrl
    import int_csr_ctrl_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter logic [31:0] CAUSE_TIMER = 32'h8000_0007,
    parameter logic [31:0] CAUSE_EXT   = 32'h8000_000B
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ecall_i,
    input  logic                  ebreak_i,
    input  logic                  mret_i,
    input  logic [31:0]           inst_addr_i,
    input  logic                  ex_jump_i,
    input  logic                  timer_int_i,
    input  logic                  ext_int_i,
    int_csr_ctrl_if.master        csr,
    output logic                  hold_o,
    output logic                  int_assert_o,
    output logic [31:0]           int_addr_o
);

    state_e            state_q, state_d;
    logic [31:0]       epc_q, epc_d;
    logic [DATA_W-1:0] cause_q, cause_d;

    logic        syncTrap;
    logic        timerTake;
    logic        extTake;
    logic        anyTrigger;
    logic [31:0] vecBase;
    logic        unused_bits;

    function automatic logic [DATA_W-1:0] trapStatus(input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] r;
        r                                = s;
        r[MSTATUS_MPIE]                  = s[MSTATUS_MIE];
        r[MSTATUS_MIE]                   = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] mretStatus(input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] r;
        r               = s;
        r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

    // Async interrupts need MIE, their mie enable bit and no redirect in flight in EX.
    assign syncTrap   = ecall_i | ebreak_i;
    assign timerTake  = timer_int_i & csr.global_int_en & csr.csr_rdata[MIE_MTIE] & ~ex_jump_i;
    assign extTake    = ext_int_i & csr.global_int_en & csr.csr_rdata[MIE_MEIE] & ~ex_jump_i;
    assign anyTrigger = syncTrap | mret_i | timerTake | extTake;
    assign vecBase    = {csr.csr_mtvec[31:2], 2'b00};

    assign csr.csr_raddr = ADDR_W'(CSR_MIE);

    assign unused_bits = ^{csr.csr_rdata, csr.csr_mtvec[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            epc_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        case (state_q)
            ST_IDLE: begin
                if (syncTrap) begin
                    state_d = ST_SAVE_EPC;
                    epc_d   = inst_addr_i;
                    cause_d = ecall_i ? DATA_W'(CAUSE_ECALL_C) : DATA_W'(CAUSE_EBREAK_C);
                end else if (mret_i) begin
                    state_d = ST_MRET_STATUS;
                end else if (timerTake || extTake) begin
                    state_d = ST_SAVE_EPC;
                    epc_d   = inst_addr_i;
                    cause_d = timerTake ? DATA_W'(CAUSE_TIMER) : DATA_W'(CAUSE_EXT);
                end
            end
            ST_SAVE_EPC:    state_d = ST_SAVE_CAUSE;
            ST_SAVE_CAUSE:  state_d = ST_SAVE_STATUS;
            ST_SAVE_STATUS: state_d = ST_JUMP;
            ST_JUMP:        state_d = ST_IDLE;
            ST_MRET_STATUS: state_d = ST_MRET_JUMP;
            ST_MRET_JUMP:   state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

    // mstatus is sampled in the save cycle itself so a same-cycle EX write at T is included.
    always_comb begin
        csr.csr_we    = 1'b0;
        csr.csr_waddr = '0;
        csr.csr_wdata = '0;
        hold_o        = 1'b0;
        int_assert_o  = 1'b0;
        int_addr_o    = '0;
        case (state_q)
            ST_IDLE: begin
                hold_o = anyTrigger;
            end
            ST_SAVE_EPC: begin
                hold_o        = 1'b1;
                csr.csr_we    = 1'b1;
                csr.csr_waddr = ADDR_W'(CSR_MEPC);
                csr.csr_wdata = DATA_W'(epc_q);
            end
            ST_SAVE_CAUSE: begin
                hold_o        = 1'b1;
                csr.csr_we    = 1'b1;
                csr.csr_waddr = ADDR_W'(CSR_MCAUSE);
                csr.csr_wdata = cause_q;
            end
            ST_SAVE_STATUS: begin
                hold_o        = 1'b1;
                csr.csr_we    = 1'b1;
                csr.csr_waddr = ADDR_W'(CSR_MSTATUS);
                csr.csr_wdata = trapStatus(csr.csr_mstatus);
            end
            ST_JUMP: begin
                hold_o       = 1'b1;
                int_assert_o = 1'b1;
`ifdef INT_VECTORED_EN
                if (csr.csr_mtvec[1:0] == 2'b01 && cause_q[DATA_W-1])
                    int_addr_o = vecBase + 32'({cause_q[4:0], 2'b00});
                else
                    int_addr_o = vecBase;
`else
                int_addr_o   = vecBase;
`endif
            end
            ST_MRET_STATUS: begin
                hold_o        = 1'b1;
                csr.csr_we    = 1'b1;
                csr.csr_waddr = ADDR_W'(CSR_MSTATUS);
                csr.csr_wdata = mretStatus(csr.csr_mstatus);
            end
            ST_MRET_JUMP: begin
                hold_o       = 1'b1;
                int_assert_o = 1'b1;
                int_addr_o   = csr.csr_mepc[31:0];
            end
            default: begin
                hold_o = 1'b0;
            end
        endcase
    end

endmodule
